// File: rtl/gt_link_ctrl.sv
// Bring-up and supervision of P_LANES GT channels sharing one QPLL: QPLL reset, per-lane TX/RX resets, timeouts, retries.
// Latency: an asynchronous status change is acted on 2 cycles after arrival (synchroniser), outputs follow 1 cycle later.
// Backpressure: none; lanes simply wait in their current state until done/aligned arrive or a timeout fires.
module gt_link_ctrl #(
    parameter int P_LANES         = 2,
    parameter int P_QPLL_RST_CYC  = 16,
    parameter int P_LANE_RST_CYC  = 16,
    parameter int P_LOCK_TIMEOUT  = 4096,
    parameter int P_DONE_TIMEOUT  = 8192,
    parameter int P_ALIGN_TIMEOUT = 8192,
    parameter int P_CNT_W         = 16
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst,
    input  logic                   i_qplllock,
    input  logic                   i_qpllrefclklost,
    output logic                   o_qpllreset,
    input  logic [P_LANES-1:0]     i_lane_reset,
    input  logic [P_LANES-1:0]     i_tx_done,
    input  logic [P_LANES-1:0]     i_rx_done,
    input  logic [P_LANES-1:0]     i_rx_aligned,
    output logic [P_LANES-1:0]     o_tx_reset,
    output logic [P_LANES-1:0]     o_rx_reset,
    output logic [P_LANES-1:0]     o_link_up,
    output logic                   o_all_up,
    output logic                   o_qpll_locked,
    output logic [8*P_LANES-1:0]   o_retry_cnt
);

    // Terminal counts; each state leaves on the cycle its counter shows the last value.
    localparam logic [P_CNT_W-1:0] QRST_LAST  = P_CNT_W'(P_QPLL_RST_CYC - 1);
    localparam logic [P_CNT_W-1:0] LRST_LAST  = P_CNT_W'(P_LANE_RST_CYC - 1);
    localparam logic [P_CNT_W-1:0] LOCK_LAST  = P_CNT_W'(P_LOCK_TIMEOUT - 1);
    localparam logic [P_CNT_W-1:0] DONE_LAST  = P_CNT_W'(P_DONE_TIMEOUT - 1);
    localparam logic [P_CNT_W-1:0] ALIGN_LAST = P_CNT_W'(P_ALIGN_TIMEOUT - 1);
    localparam logic [P_CNT_W-1:0] CNT_ONE    = P_CNT_W'(1);

    typedef enum logic [1:0] {
        Q_RESET,
        Q_WAIT_LOCK,
        Q_LOCKED
    } q_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_RESET,
        L_WAIT_DONE,
        L_WAIT_ALIGN,
        L_RX_RST,
        L_UP
    } l_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for every asynchronous status input
    // ------------------------------------------------------------------
    logic               lock_meta, lock_sync;
    logic               lost_meta, lost_sync;
    logic [P_LANES-1:0] tx_done_meta, tx_done_sync;
    logic [P_LANES-1:0] rx_done_meta, rx_done_sync;
    logic [P_LANES-1:0] aligned_meta, aligned_sync;

    // Bring GT-domain status into the controller clock domain.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            lock_meta    <= 1'b0;
            lock_sync    <= 1'b0;
            lost_meta    <= 1'b0;
            lost_sync    <= 1'b0;
            tx_done_meta <= '0;
            tx_done_sync <= '0;
            rx_done_meta <= '0;
            rx_done_sync <= '0;
            aligned_meta <= '0;
            aligned_sync <= '0;
        end else begin
            lock_meta    <= i_qplllock;
            lock_sync    <= lock_meta;
            lost_meta    <= i_qpllrefclklost;
            lost_sync    <= lost_meta;
            tx_done_meta <= i_tx_done;
            tx_done_sync <= tx_done_meta;
            rx_done_meta <= i_rx_done;
            rx_done_sync <= rx_done_meta;
            aligned_meta <= i_rx_aligned;
            aligned_sync <= aligned_meta;
        end
    end

    // ------------------------------------------------------------------
    // Common (QPLL) FSM
    // ------------------------------------------------------------------
    q_state_t           q_state;
    logic [P_CNT_W-1:0] q_cnt;
    logic               q_drop;
    logic               q_up;

    // Loss of lock or reference while locked; lanes react in the same cycle the common FSM does.
    assign q_drop = (q_state == Q_LOCKED) && (!lock_sync || lost_sync);
    // Lanes may only run while the QPLL is locked and staying locked.
    assign q_up   = (q_state == Q_LOCKED) && !q_drop;

    // QPLL reset pulse, lock wait with timeout, and lock supervision.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            q_state       <= Q_RESET;
            q_cnt         <= '0;
            o_qpllreset   <= 1'b1;
            o_qpll_locked <= 1'b0;
        end else begin
            case (q_state)
                Q_RESET: begin
                    if (q_cnt == QRST_LAST) begin
                        q_state     <= Q_WAIT_LOCK;
                        q_cnt       <= '0;
                        o_qpllreset <= 1'b0;
                    end else begin
                        q_cnt <= q_cnt + CNT_ONE;
                    end
                end
                Q_WAIT_LOCK: begin
                    if (lock_sync) begin
                        q_state       <= Q_LOCKED;
                        q_cnt         <= '0;
                        o_qpll_locked <= 1'b1;
                    end else if (q_cnt == LOCK_LAST) begin
                        q_state     <= Q_RESET;
                        q_cnt       <= '0;
                        o_qpllreset <= 1'b1;
                    end else begin
                        q_cnt <= q_cnt + CNT_ONE;
                    end
                end
                Q_LOCKED: begin
                    if (q_drop) begin
                        q_state       <= Q_RESET;
                        q_cnt         <= '0;
                        o_qpllreset   <= 1'b1;
                        o_qpll_locked <= 1'b0;
                    end
                end
                default: begin
                    q_state       <= Q_RESET;
                    q_cnt         <= '0;
                    o_qpllreset   <= 1'b1;
                    o_qpll_locked <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-lane FSMs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < P_LANES; g++) begin : gen_lane
        l_state_t           state;
        logic [P_CNT_W-1:0] cnt;
        logic [7:0]         retry;
        logic               tx_rst;
        logic               rx_rst;
        logic               up;
        logic               done_ok;

        assign done_ok = tx_done_sync[g] & rx_done_sync[g];

        // Lane sequencing; QPLL loss beats manual restart, which beats every lane-local event.
        always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
            if (i_sys_rst) begin
                state  <= L_IDLE;
                cnt    <= '0;
                retry  <= '0;
                tx_rst <= 1'b1;
                rx_rst <= 1'b1;
                up     <= 1'b0;
            end else if (!q_up) begin
                state  <= L_IDLE;
                cnt    <= '0;
                tx_rst <= 1'b1;
                rx_rst <= 1'b1;
                up     <= 1'b0;
            end else if (i_lane_reset[g] && (state != L_IDLE)) begin
                state  <= L_RESET;
                cnt    <= '0;
                tx_rst <= 1'b1;
                rx_rst <= 1'b1;
                up     <= 1'b0;
            end else begin
                case (state)
                    L_IDLE: begin
                        state  <= L_RESET;
                        cnt    <= '0;
                        tx_rst <= 1'b1;
                        rx_rst <= 1'b1;
                    end
                    L_RESET: begin
                        if (cnt == LRST_LAST) begin
                            state  <= L_WAIT_DONE;
                            cnt    <= '0;
                            tx_rst <= 1'b0;
                            rx_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    L_WAIT_DONE: begin
                        if (done_ok) begin
                            state <= L_WAIT_ALIGN;
                            cnt   <= '0;
                        end else if (cnt == DONE_LAST) begin
                            state  <= L_RESET;
                            cnt    <= '0;
                            tx_rst <= 1'b1;
                            rx_rst <= 1'b1;
                            if (retry != 8'hFF) retry <= retry + 8'd1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    L_WAIT_ALIGN: begin
                        if (aligned_sync[g]) begin
                            state <= L_UP;
                            cnt   <= '0;
                            up    <= 1'b1;
                        end else if (cnt == ALIGN_LAST) begin
                            // Alignment failures only need the receiver restarted.
                            state  <= L_RX_RST;
                            cnt    <= '0;
                            rx_rst <= 1'b1;
                            if (retry != 8'hFF) retry <= retry + 8'd1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    L_RX_RST: begin
                        if (cnt == LRST_LAST) begin
                            state  <= L_WAIT_DONE;
                            cnt    <= '0;
                            rx_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    L_UP: begin
                        if (!done_ok) begin
                            state  <= L_RESET;
                            cnt    <= '0;
                            tx_rst <= 1'b1;
                            rx_rst <= 1'b1;
                            up     <= 1'b0;
                            if (retry != 8'hFF) retry <= retry + 8'd1;
                        end else if (!aligned_sync[g]) begin
                            // A lost comma is re-acquired without resetting the channel.
                            state <= L_WAIT_ALIGN;
                            cnt   <= '0;
                            up    <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= L_IDLE;
                        cnt    <= '0;
                        tx_rst <= 1'b1;
                        rx_rst <= 1'b1;
                        up     <= 1'b0;
                    end
                endcase
            end
        end

        assign o_tx_reset[g]          = tx_rst;
        assign o_rx_reset[g]          = rx_rst;
        assign o_link_up[g]           = up;
        assign o_retry_cnt[8*g +: 8]  = retry;
    end

    // Aggregate link status, one cycle behind the per-lane flags.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            o_all_up <= 1'b0;
        end else begin
            o_all_up <= &o_link_up;
        end
    end

endmodule

// File: tb/tb_gt_link_ctrl.sv
// Self-checking bench for gt_link_ctrl with two lanes and short reset/timeout parameters.
// Expected behaviour is predicted as event times derived from the controller's timing rules.
// Each scenario task compares the full status vector and retry counts every cycle.
module tb_gt_link_ctrl;

    localparam int NL = 2;
    localparam int QR = 4;
    localparam int LR = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            lock, lost;
    logic [NL-1:0]   lane_rst, tx_done, rx_done, aligned;
    logic            qpllreset, all_up, qpll_locked;
    logic [NL-1:0]   tx_reset, rx_reset, link_up;
    logic [8*NL-1:0] retry;
    logic [8:0]      obs;
    logic [8:0]      exp_v;
    logic [15:0]     exp_r;

    int cyc;
    int n_checks;
    int n_fail;
    int r0_model;
    int r1_model;

    always #5 clk = ~clk;

    assign obs = {qpllreset, qpll_locked, all_up, link_up, tx_reset, rx_reset};

    gt_link_ctrl #(
        .P_LANES(NL), .P_QPLL_RST_CYC(QR), .P_LANE_RST_CYC(LR),
        .P_LOCK_TIMEOUT(TO), .P_DONE_TIMEOUT(TO), .P_ALIGN_TIMEOUT(TO), .P_CNT_W(16)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_qplllock(lock), .i_qpllrefclklost(lost),
        .o_qpllreset(qpllreset),
        .i_lane_reset(lane_rst), .i_tx_done(tx_done), .i_rx_done(rx_done), .i_rx_aligned(aligned),
        .o_tx_reset(tx_reset), .o_rx_reset(rx_reset), .o_link_up(link_up),
        .o_all_up(all_up), .o_qpll_locked(qpll_locked), .o_retry_cnt(retry)
    );

    function automatic logic [8:0] pack(input bit q, input bit lk, input bit au,
                                        input logic [1:0] lu, input logic [1:0] tx,
                                        input logic [1:0] rx);
        return {q, lk, au, lu, tx, rx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        lock = 1'b0; lost = 1'b0;
        lane_rst = '0; tx_done = '0; rx_done = '0; aligned = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        r0_model = 0;
        r1_model = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lock = 1'b0; lost = 1'b0;
        lane_rst = '0; tx_done = '1; rx_done = '1; aligned = '1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 9'b1_0_0_00_11_11) begin
            n_fail++;
            $display("FAIL reset_status got=%b want=%b", obs, 9'b1_0_0_00_11_11);
        end
        n_checks++;
        if (retry !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_retry got=%h want=0000", retry);
        end
    endtask

    // Clean bring-up with random lock, done and alignment arrival times.
    task automatic test_bringup();
        int k0, rdrop, last;
        int d[NL];
        int a[NL];
        int up[NL];
        logic [1:0] lu;
        apply_reset();
        k0 = $urandom_range(5, 30);
        rdrop = k0 + 3 + 1 + LR;
        last = 0;
        for (int n = 0; n < NL; n++) begin
            d[n] = $urandom_range(0, 10);
            a[n] = $urandom_range(1, 30);
            up[n] = rdrop + d[n] + a[n] + 3;
            if (up[n] > last) last = up[n];
        end
        forever begin
            for (int n = 0; n < NL; n++) lu[n] = (cyc >= up[n]);
            exp_v = pack(cyc < QR, cyc >= k0 + 3, cyc >= last + 1, lu,
                         {2{cyc < rdrop}}, {2{cyc < rdrop}});
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bringup_status cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            n_checks++;
            if (retry !== 16'h0000) begin
                n_fail++;
                $display("FAIL bringup_retry cyc=%0d got=%h want=0000", cyc, retry);
            end
            if (cyc >= last + 6) break;
            if (cyc == k0) lock = 1'b1;
            for (int n = 0; n < NL; n++) begin
                if (cyc == rdrop + d[n]) begin
                    tx_done[n] = 1'b1;
                    rx_done[n] = 1'b1;
                end
                if (cyc == rdrop + d[n] + a[n]) aligned[n] = 1'b1;
            end
            tick();
        end
    endtask

    // No lock ever: QPLL reset re-pulses every QR+TO cycles; lane noise must be ignored.
    task automatic test_lock_timeout();
        apply_reset();
        forever begin
            exp_v = pack((cyc % (QR + TO)) < QR, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lock_timeout_status cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            n_checks++;
            if (retry !== 16'h0000) begin
                n_fail++;
                $display("FAIL lock_timeout_retry cyc=%0d got=%h want=0000", cyc, retry);
            end
            if (cyc >= 3 * (QR + TO) + 8) break;
            lost     = 1'($urandom);
            lane_rst = 2'($urandom);
            tx_done  = 2'($urandom);
            rx_done  = 2'($urandom);
            aligned  = 2'($urandom);
            tick();
        end
    endtask

    // Lane 1 rx_done never arrives: lane 1 retries until its counter saturates; lane 0 stays up.
    task automatic test_done_timeout();
        int k0, rdrop, d, a, up0, t1, r1;
        bit rst1;
        apply_reset();
        k0 = $urandom_range(5, 20);
        rdrop = k0 + 3 + 1 + LR;
        d = $urandom_range(0, 5);
        a = $urandom_range(1, 20);
        up0 = rdrop + d + a + 3;
        t1 = rdrop + TO;
        forever begin
            rst1 = (cyc < rdrop) || (cyc >= t1 && ((cyc - t1) % (LR + TO)) < LR);
            r1 = (cyc < t1) ? 0 : ((cyc - t1) / (LR + TO) + 1);
            if (r1 > 255) r1 = 255;
            exp_v = pack(cyc < QR, cyc >= k0 + 3, 1'b0, {1'b0, cyc >= up0},
                         {rst1, cyc < rdrop}, {rst1, cyc < rdrop});
            exp_r = {8'(r1), 8'd0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL done_timeout_status cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            n_checks++;
            if (retry !== exp_r) begin
                n_fail++;
                $display("FAIL done_timeout_retry cyc=%0d got=%h want=%h", cyc, retry, exp_r);
            end
            if (cyc >= t1 + 258 * (LR + TO)) break;
            if (cyc == k0) lock = 1'b1;
            if (cyc == rdrop + d) begin
                tx_done = 2'b11;
                rx_done = 2'b01;
            end
            if (cyc == rdrop + d + a) aligned = 2'b11;
            tick();
        end
    endtask

    // Lane 0 alignment late: one RX-only restart, then it comes up; DUT left with both lanes up.
    task automatic test_align_timeout();
        int k0, rdrop, d, a1, e, up0, up1, last;
        bit rx0;
        apply_reset();
        k0 = $urandom_range(5, 20);
        rdrop = k0 + 3 + 1 + LR;
        d = $urandom_range(0, 5);
        a1 = $urandom_range(1, 20);
        e = rdrop + d + 3;
        up1 = rdrop + d + a1 + 3;
        up0 = e + TO + LR + 1 + 14;
        last = (up0 > up1) ? up0 : up1;
        forever begin
            rx0 = (cyc < rdrop) || (cyc >= e + TO && cyc < e + TO + LR);
            r0_model = (cyc >= e + TO) ? 1 : 0;
            exp_v = pack(cyc < QR, cyc >= k0 + 3, cyc >= last + 1, {cyc >= up1, cyc >= up0},
                         {cyc < rdrop, cyc < rdrop}, {cyc < rdrop, rx0});
            exp_r = {8'(r1_model), 8'(r0_model)};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL align_timeout_status cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            n_checks++;
            if (retry !== exp_r) begin
                n_fail++;
                $display("FAIL align_timeout_retry cyc=%0d got=%h want=%h", cyc, retry, exp_r);
            end
            if (cyc >= last + 6) break;
            if (cyc == k0) lock = 1'b1;
            if (cyc == rdrop + d) begin
                tx_done = 2'b11;
                rx_done = 2'b11;
            end
            if (cyc == rdrop + d + a1) aligned[1] = 1'b1;
            if (cyc == up0 - 3) aligned[0] = 1'b1;
            tick();
        end
    endtask

    // One-cycle lock drop: every lane back to idle, QPLL re-pulsed, full bring-up repeats.
    task automatic test_lock_drop();
        int dd, stop;
        bit lanes_rst, down, au_down, q_rst, unlocked;
        dd = cyc + $urandom_range(2, 10);
        stop = dd + 22;
        forever begin
            q_rst     = (cyc >= dd + 3) && (cyc < dd + 3 + QR);
            unlocked  = (cyc >= dd + 3) && (cyc < dd + 4 + QR);
            lanes_rst = (cyc >= dd + 3) && (cyc < dd + 5 + QR + LR);
            down      = (cyc >= dd + 3) && (cyc < dd + 7 + QR + LR);
            au_down   = (cyc >= dd + 4) && (cyc < dd + 8 + QR + LR);
            exp_v = pack(q_rst, !unlocked, !au_down, {2{!down}}, {2{lanes_rst}}, {2{lanes_rst}});
            exp_r = {8'(r1_model), 8'(r0_model)};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lock_drop_status cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            n_checks++;
            if (retry !== exp_r) begin
                n_fail++;
                $display("FAIL lock_drop_retry cyc=%0d got=%h want=%h", cyc, retry, exp_r);
            end
            if (cyc >= stop) break;
            if (cyc == dd) lock = 1'b0;
            if (cyc == dd + 1) lock = 1'b1;
            tick();
        end
    endtask

    // Alignment glitch on lane 0 of random length: re-acquire without any reset or retry.
    task automatic test_align_drop();
        int aa, len, stop;
        bit down, au_down;
        aa = cyc + $urandom_range(2, 6);
        len = $urandom_range(1, 10);
        stop = aa + len + 10;
        forever begin
            down    = (cyc >= aa + 3) && (cyc < aa + 3 + len);
            au_down = (cyc >= aa + 4) && (cyc < aa + 4 + len);
            exp_v = pack(1'b0, 1'b1, !au_down, {1'b1, !down}, 2'b00, 2'b00);
            exp_r = {8'(r1_model), 8'(r0_model)};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL align_drop_status cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            n_checks++;
            if (retry !== exp_r) begin
                n_fail++;
                $display("FAIL align_drop_retry cyc=%0d got=%h want=%h", cyc, retry, exp_r);
            end
            if (cyc >= stop) break;
            if (cyc == aa) aligned[0] = 1'b0;
            if (cyc == aa + len) aligned[0] = 1'b1;
            tick();
        end
    endtask

    // Manual restart of lane 0: one LR-cycle TX+RX reset pulse, no retry increment.
    task automatic test_lane_reset();
        int bb, stop;
        bit pulse, down, au_down;
        bb = cyc + $urandom_range(2, 6);
        stop = bb + 12;
        forever begin
            pulse   = (cyc >= bb + 1) && (cyc < bb + 1 + LR);
            down    = (cyc >= bb + 1) && (cyc < bb + 3 + LR);
            au_down = (cyc >= bb + 2) && (cyc < bb + 4 + LR);
            exp_v = pack(1'b0, 1'b1, !au_down, {1'b1, !down}, {1'b0, pulse}, {1'b0, pulse});
            exp_r = {8'(r1_model), 8'(r0_model)};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lane_reset_status cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            n_checks++;
            if (retry !== exp_r) begin
                n_fail++;
                $display("FAIL lane_reset_retry cyc=%0d got=%h want=%h", cyc, retry, exp_r);
            end
            if (cyc >= stop) break;
            lane_rst = (cyc == bb) ? 2'b01 : 2'b00;
            tick();
        end
    endtask

    // Reset asserted between clock edges must clear outputs without waiting for a clock.
    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 9'b1_0_0_00_11_11) begin
            n_fail++;
            $display("FAIL async_reset_status got=%b want=%b", obs, 9'b1_0_0_00_11_11);
        end
        n_checks++;
        if (retry !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_retry got=%h want=0000", retry);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        r0_model = 0;
        r1_model = 0;
        test_reset();
        test_bringup();
        test_lock_timeout();
        test_done_timeout();
        test_align_timeout();
        test_lock_drop();
        test_align_drop();
        test_lane_reset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
